// File: rtl/lcd_init_pkg.sv
// lcd_init_pkg: state codes, default timings and nibble constants for the LCD wake-up sequencer
package lcd_init_pkg;

    localparam int DEF_T_PWR  = 750000;
    localparam int DEF_T_GAP1 = 205000;
    localparam int DEF_T_GAP2 = 5000;
    localparam int DEF_T_GAP3 = 2000;
    localparam int DEF_T_SU   = 2;
    localparam int DEF_T_E    = 12;
    localparam int DEF_T_H    = 1;

    // Each write k occupies four consecutive codes (SETUPk, PULSEk, HOLDk, WAITk),
    // so the sequence always advances by +1 and (state-1) splits into {k, phase}.
    localparam logic [4:0] WAIT_PWR = 5'd0;
    localparam logic [4:0] SETUP0   = 5'd1;
    localparam logic [4:0] PULSE0   = 5'd2;
    localparam logic [4:0] HOLD0    = 5'd3;
    localparam logic [4:0] WAIT0    = 5'd4;
    localparam logic [4:0] SETUP1   = 5'd5;
    localparam logic [4:0] PULSE1   = 5'd6;
    localparam logic [4:0] HOLD1    = 5'd7;
    localparam logic [4:0] WAIT1    = 5'd8;
    localparam logic [4:0] SETUP2   = 5'd9;
    localparam logic [4:0] PULSE2   = 5'd10;
    localparam logic [4:0] HOLD2    = 5'd11;
    localparam logic [4:0] WAIT2    = 5'd12;
    localparam logic [4:0] SETUP3   = 5'd13;
    localparam logic [4:0] PULSE3   = 5'd14;
    localparam logic [4:0] HOLD3    = 5'd15;
    localparam logic [4:0] WAIT3    = 5'd16;
    localparam logic [4:0] DONE     = 5'd17;

    localparam logic [3:0] NIB_WAKE = 4'h3;
    localparam logic [3:0] NIB_4BIT = 4'h2;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    // Bits needed to count 0..m-1
    function automatic int cnt_width(input int m);
        return m > 1 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// lcd_nibble_strobe: SETUP/PULSE/HOLD timing for one nibble write, paced by the shared counter
module lcd_nibble_strobe
    import lcd_init_pkg::*;
#(
    parameter int T_SU = DEF_T_SU,
    parameter int T_E  = DEF_T_E,
    parameter int T_H  = DEF_T_H,
    parameter int CW   = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [3:0]    i_nib,
    input  logic [CW-1:0] i_cnt,
    output logic          o_adv,
    output logic          o_done,
    output logic          o_e,
    output logic [3:0]    o_nib
);

    // phase: 0 idle, 1 setup, 2 pulse, 3 hold; 3+1 wraps back to idle
    logic [1:0]    r_phase;
    logic [1:0]    w_next;
    logic [CW-1:0] w_last;

    // End-of-phase detection against the shared counter and next-phase selection
    always_comb begin
        w_last = r_phase == 2'd1 ? CW'(T_SU - 1) : r_phase == 2'd2 ? CW'(T_E - 1) : CW'(T_H - 1);
        o_adv  = r_phase != 2'd0 && i_cnt == w_last;
        o_done = o_adv && r_phase == 2'd3;
        w_next = i_start ? 2'd1 : o_adv ? r_phase + 2'd1 : r_phase;
    end

    // Registered strobe and nibble; the nibble only loads on entry to setup
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= 2'd0;
            o_e     <= 1'b0;
            o_nib   <= 4'h0;
        end else begin
            r_phase <= w_next;
            o_e     <= w_next == 2'd2;
            if (i_start)
                o_nib <= i_nib;
        end
    end

endmodule

// File: rtl/lcd_init_fsm.sv
// lcd_init_fsm: HD44780 4-bit power-on wake-up sequencer (0x3, 0x3, 0x3, 0x2 with mandated gaps)
module lcd_init_fsm
    import lcd_init_pkg::*;
#(
    parameter int T_PWR  = DEF_T_PWR,
    parameter int T_GAP1 = DEF_T_GAP1,
    parameter int T_GAP2 = DEF_T_GAP2,
    parameter int T_GAP3 = DEF_T_GAP3,
    parameter int T_SU   = DEF_T_SU,
    parameter int T_E    = DEF_T_E,
    parameter int T_H    = DEF_T_H
) (
    input  logic clk,
    input  logic reset,
    output logic LCD_E,
    output logic LCD_RS,
    output logic LCD_RW,
    output logic SF_D8,
    output logic SF_D9,
    output logic SF_D10,
    output logic SF_D11,
    output logic init_done
);

    localparam int CW = cnt_width(max2(max2(max2(T_PWR, T_GAP1), max2(T_GAP2, T_GAP3)),
                                       max2(max2(T_SU, T_E), T_H)));

    logic [4:0]    r_state;
    logic [4:0]    w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_wait_last;
    logic [3:0]    w_off;
    logic [3:0]    w_noff;
    logic          w_in_strobe;
    logic          w_start;
    logic          w_adv;
    logic          w_done;
    logic [3:0]    w_nib;
    logic [3:0]    w_nib_q;

    assign LCD_RS = 1'b0;
    assign LCD_RW = 1'b0;
    assign {SF_D11, SF_D10, SF_D9, SF_D8} = w_nib_q;

    // Sequence control: waits are timed here, strobe phases by the sub-module
    always_comb begin
        w_off       = 4'(r_state - 5'd1);
        w_in_strobe = r_state != WAIT_PWR && r_state != DONE && w_off[1:0] != 2'd3;
        w_wait_last = r_state == WAIT_PWR ? CW'(T_PWR - 1) :
                      w_off[3:2] == 2'd0  ? CW'(T_GAP1 - 1) :
                      w_off[3:2] == 2'd1  ? CW'(T_GAP2 - 1) : CW'(T_GAP3 - 1);
        w_next      = r_state == DONE ? DONE :
                      (w_in_strobe ? (w_off[1:0] == 2'd2 ? w_done : w_adv) : r_cnt == w_wait_last) ?
                      r_state + 5'd1 : r_state;
        w_noff      = 4'(w_next - 5'd1);
        w_start     = w_next != r_state && w_next != DONE && w_noff[1:0] == 2'd0;
        w_nib       = w_noff[3:2] == 2'd3 ? NIB_4BIT : NIB_WAKE;
    end

    // State, shared counter (reloads to 0 on every state change) and done flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= WAIT_PWR;
            r_cnt     <= '0;
            init_done <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_next != r_state ? '0 : r_cnt + 1'b1;
            init_done <= w_next == DONE;
        end
    end

    lcd_nibble_strobe #(
        .T_SU (T_SU),
        .T_E  (T_E),
        .T_H  (T_H),
        .CW   (CW)
    ) u_strobe (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_nib   (w_nib),
        .i_cnt   (r_cnt),
        .o_adv   (w_adv),
        .o_done  (w_done),
        .o_e     (LCD_E),
        .o_nib   (w_nib_q)
    );

endmodule

// File: tb/tb_lcd_init_fsm.sv
// tb_lcd_init_fsm: randomized reset stimulus on two scaled configurations against a segment-based timing model
module tb_lcd_init_fsm;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic s_e, s_rs, s_rw, s_d8, s_d9, s_d10, s_d11, s_done;
    logic b_e, b_rs, b_rw, b_d8, b_d9, b_d10, b_d11, b_done;

    lcd_init_fsm #(
        .T_PWR(50), .T_GAP1(40), .T_GAP2(20), .T_GAP3(10), .T_SU(2), .T_E(12), .T_H(1)
    ) dut_s (
        .clk(clk), .reset(reset), .LCD_E(s_e), .LCD_RS(s_rs), .LCD_RW(s_rw),
        .SF_D8(s_d8), .SF_D9(s_d9), .SF_D10(s_d10), .SF_D11(s_d11), .init_done(s_done)
    );

    lcd_init_fsm #(
        .T_PWR(30), .T_GAP1(17), .T_GAP2(9), .T_GAP3(4), .T_SU(3), .T_E(5), .T_H(2)
    ) dut_b (
        .clk(clk), .reset(reset), .LCD_E(b_e), .LCD_RS(b_rs), .LCD_RW(b_rw),
        .SF_D8(b_d8), .SF_D9(b_d9), .SF_D10(b_d10), .SF_D11(b_d11), .init_done(b_done)
    );

    int errs = 0;
    int checks = 0;
    int c = 0;
    int rises[$];
    int falls[$];
    logic [3:0] rnib[$];
    int done_at = -1;
    logic ps_e = 1'b0, pb_e = 1'b0, ps_done = 1'b0;
    logic [3:0] ps_n = 4'h0, pb_n = 4'h0;

    // Expected {init_done, LCD_E, nibble} after c clock edges with reset released
    function automatic logic [5:0] model(input int c, input int pwr, input int su, input int te,
                                         input int th, input int g1, input int g2, input int g3);
        int t;
        int g;
        logic [3:0] nib;
        if (c < pwr) return 6'h00;
        t = c - pwr;
        for (int k = 0; k < 4; k++) begin
            g = k == 0 ? g1 : k == 1 ? g2 : g3;
            nib = k == 3 ? 4'h2 : 4'h3;
            if (t < su + te + th + g) return {1'b0, t >= su && t < su + te, nib};
            t -= su + te + th + g;
        end
        return {1'b1, 1'b0, 4'h2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    // Apply reset level for one edge, then compare both instances against the model
    task automatic step(input logic r);
        logic [5:0] ms, mb;
        logic [3:0] sn, bn;
        reset = r;
        @(posedge clk);
        #1;
        c = r ? c + 1 : 0;
        ms = model(c, 50, 2, 12, 1, 40, 20, 10);
        mb = model(c, 30, 3, 5, 2, 17, 9, 4);
        sn = {s_d11, s_d10, s_d9, s_d8};
        bn = {b_d11, b_d10, b_d9, b_d8};
        chk("s_out", {s_done, s_e, sn}, ms);
        chk("b_out", {b_done, b_e, bn}, mb);
        chk("rs_rw", {s_rs, s_rw, b_rs, b_rw}, 4'h0);
        chk("s_data_vs_e", r && s_e !== ps_e && sn !== ps_n, 1'b0);
        chk("b_data_vs_e", r && b_e !== pb_e && bn !== pb_n, 1'b0);
        if (s_e && !ps_e) begin
            rises.push_back(c);
            rnib.push_back(sn);
        end
        if (!s_e && ps_e && r) falls.push_back(c);
        if (s_done && !ps_done) done_at = c;
        ps_e = s_e;
        pb_e = b_e;
        ps_n = sn;
        pb_n = bn;
        ps_done = s_done;
    endtask

    int exp_gap[3] = '{43, 23, 13};
    logic [3:0] exp_nib[4] = '{4'h3, 4'h3, 4'h3, 4'h2};

    initial begin
        // Reset held for three edges
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("reset_e", s_e, 1'b0);
        chk("reset_nib", {s_d11, s_d10, s_d9, s_d8}, 4'h0);
        chk("reset_done", s_done, 1'b0);

        // Full scaled sequence plus 1000 idle cycles in DONE
        rises.delete(); falls.delete(); rnib.delete(); done_at = -1;
        for (int i = 0; i < 1190; i++) step(1'b1);
        chk("n_rises", rises.size(), 4);
        chk("n_falls", falls.size(), 4);
        chk("first_rise", rises.size() > 0 ? rises[0] : -1, 52);
        chk("done_at", done_at, 190);
        for (int i = 0; i < 4 && i < rises.size(); i++) begin
            chk("nib_at_rise", rnib[i], exp_nib[i]);
            if (i < falls.size()) chk("pulse_width", falls[i] - rises[i], 12);
            if (i > 0 && i - 1 < falls.size()) chk("gap", rises[i] - falls[i-1], exp_gap[i-1]);
        end
        chk("post_done", {s_done, s_e, s_d11, s_d10, s_d9, s_d8}, 6'b10_0010);

        // Reset for one edge in the middle of the second pulse
        step(1'b0);
        for (int i = 0; i < 110; i++) step(1'b1);
        chk("in_pulse2", s_e, 1'b1);
        step(1'b0);
        chk("midrst_e", s_e, 1'b0);
        chk("midrst_nib", {s_d11, s_d10, s_d9, s_d8}, 4'h0);
        rises.delete(); falls.delete(); rnib.delete(); done_at = -1;
        for (int i = 0; i < 195; i++) step(1'b1);
        chk("rst_first_rise", rises.size() > 0 ? rises[0] : -1, 52);
        chk("rst_n_rises", rises.size(), 4);
        chk("rst_done_at", done_at, 190);

        // Random reset pulses of random length across both configurations
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 179) == 0) begin
                for (int j = $urandom_range(1, 3); j > 0; j--) step(1'b0);
            end else begin
                step(1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
